// File: rtl/adda_capture_sequencer_pkg.sv
// Shared definitions for the AD9280 triggered capture sequencer: state codes,
// sample widths and the level-crossing comparator.
package adda_capture_sequencer_pkg;

    localparam int unsigned AD_DATA_W = 8;
    localparam int unsigned DA_DATA_W = 8;
    localparam int unsigned CMP_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_READOUT = 3'd4
    } cap_state_e;

    // Unsigned threshold crossing between two consecutive samples.
    function automatic logic level_crossed(
        input logic             rising,
        input logic [CMP_W-1:0] prev,
        input logic [CMP_W-1:0] cur,
        input logic [CMP_W-1:0] level
    );
        if (rising) begin
            return (prev < level) && (cur >= level);
        end else begin
            return (prev >= level) && (cur < level);
        end
    endfunction

endpackage

// File: rtl/adda_capture_sequencer_if.sv
// Readout stream of the capture sequencer: valid/ready beats with a last marker.
interface adda_capture_sequencer_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              rd_ready;

    modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
    modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);

endinterface

// File: rtl/adda_capture_sequencer_sample_ram.sv
// Simple dual-port sample buffer: one write port, registered read with one cycle latency.
module adda_sample_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // No reset on the array or read register so the buffer maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/adda_capture_sequencer.sv
// Triggered capture controller: circular pre-trigger buffer, level/forced trigger,
// and oldest-first readout of the DEPTH-sample window over a valid/ready stream.
module adda_capture_sequencer
    import adda_capture_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W     = AD_DATA_W,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_W-1:0]     i_ad_sample,
    input  logic                  i_arm,
    input  logic                  i_abort,
    input  logic                  i_force_trig,
    input  logic                  i_trig_rising,
    input  logic [DATA_W-1:0]     i_trig_level,
    input  logic [DEPTH_LOG2-1:0] i_pretrig,
    output logic                  o_busy,
    output logic [2:0]            o_state,
    output logic                  o_done,
    adda_capture_sequencer_if.master rd_if
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX   = '1;
    localparam logic [DEPTH_LOG2:0]   BEATS     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LAST_BEAT = BEATS - (DEPTH_LOG2 + 1)'(1);

    cap_state_e            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_addr_q, rd_addr_d;
    logic [DEPTH_LOG2-1:0] p_q, p_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [DEPTH_LOG2:0]   rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0]     prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;
    logic                  ram_vld_q, ram_vld_d;
    logic                  ram_last_q, ram_last_d;
    logic                  out_vld_q, out_vld_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  skid_vld_q, skid_vld_d;
    logic                  skid_last_q, skid_last_d;
    logic [DATA_W-1:0]     skid_data_q, skid_data_d;
    logic                  done_q, done_d;

    logic                  we_s;
    logic                  re_s;
    logic [DATA_W-1:0]     ram_rdata_s;
    logic                  pop_s;
    logic [1:0]            occ_s;
    logic                  trig_s;

    adda_sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (we_s),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_ad_sample),
        .i_re    (re_s),
        .i_raddr (rd_addr_q),
        .o_rdata (ram_rdata_s)
    );

    // State, pointers and readout pipeline registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_addr_q   <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_addr_q   <= rd_addr_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            ram_vld_q   <= ram_vld_d;
            ram_last_q  <= ram_last_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state, buffer writes, trigger detection and readout flow control.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_addr_d   = rd_addr_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        prev_d      = i_ad_sample;
        prev_vld_d  = prev_vld_q;
        ram_vld_d   = 1'b0;
        ram_last_d  = 1'b0;
        out_vld_d   = out_vld_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        skid_vld_d  = skid_vld_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;
        done_d      = 1'b0;
        we_s        = 1'b0;
        re_s        = 1'b0;
        pop_s       = out_vld_q & rd_if.rd_ready;
        // Entries held or in flight after this cycle; a new read needs room for one more.
        occ_s       = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q) - 2'(pop_s);
        trig_s      = i_force_trig |
                      (prev_vld_q & level_crossed(i_trig_rising, CMP_W'(prev_q),
                                                  CMP_W'(i_ad_sample), CMP_W'(i_trig_level)));

        if (i_abort) begin
            state_d    = ST_IDLE;
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_arm) begin
                        p_d        = i_pretrig;
                        cnt_d      = i_pretrig;
                        wr_ptr_d   = '0;
                        rd_cnt_d   = '0;
                        prev_vld_d = 1'b0;
                        state_d    = (i_pretrig == '0) ? ST_ARMED : ST_PREFILL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREFILL: begin
                    we_s       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    prev_vld_d = 1'b1;
                    cnt_d      = cnt_q - PTR_ONE;
                    if (cnt_q == PTR_ONE) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_PREFILL;
                    end
                end
                ST_ARMED: begin
                    we_s       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    prev_vld_d = 1'b1;
                    if (trig_s) begin
                        // Window start is fixed now; the trigger address is wr_ptr_q.
                        rd_addr_d = wr_ptr_q - p_q;
                        cnt_d     = PTR_MAX - p_q;
                        state_d   = (p_q == PTR_MAX) ? ST_READOUT : ST_POST;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_POST: begin
                    we_s     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    cnt_d    = cnt_q - PTR_ONE;
                    if (cnt_q == PTR_ONE) begin
                        state_d = ST_READOUT;
                    end else begin
                        state_d = ST_POST;
                    end
                end
                ST_READOUT: begin
                    if ((rd_cnt_q != BEATS) && (occ_s <= 2'd1)) begin
                        re_s       = 1'b1;
                        rd_addr_d  = rd_addr_q + PTR_ONE;
                        rd_cnt_d   = rd_cnt_q + (DEPTH_LOG2 + 1)'(1);
                        ram_vld_d  = 1'b1;
                        ram_last_d = (rd_cnt_q == LAST_BEAT);
                    end else begin
                        re_s = 1'b0;
                    end
                    // Output register is the head; the skid entry absorbs a read landing during a stall.
                    if (!out_vld_q || pop_s) begin
                        if (skid_vld_q) begin
                            out_vld_d   = 1'b1;
                            out_data_d  = skid_data_q;
                            out_last_d  = skid_last_q;
                            skid_vld_d  = ram_vld_q;
                            skid_data_d = ram_rdata_s;
                            skid_last_d = ram_last_q;
                        end else begin
                            out_vld_d  = ram_vld_q;
                            out_data_d = ram_rdata_s;
                            out_last_d = ram_last_q;
                        end
                    end else if (ram_vld_q) begin
                        skid_vld_d  = 1'b1;
                        skid_data_d = ram_rdata_s;
                        skid_last_d = ram_last_q;
                    end else begin
                        skid_vld_d = skid_vld_q;
                    end
                    if (pop_s && out_last_q) begin
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                        skid_vld_d = 1'b0;
                    end else begin
                        state_d = ST_READOUT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy         = (state_q != ST_IDLE);
    assign o_state        = state_q;
    assign o_done         = done_q;
    assign rd_if.rd_data  = out_data_q;
    assign rd_if.rd_valid = out_vld_q;
    assign rd_if.rd_last  = out_last_q;

endmodule

// File: tb/tb_adda_capture_sequencer.sv
// Scoreboard bench for adda_capture_sequencer with DEPTH=16 and directed ramp/level stimulus.
module tb_adda_capture_sequencer;
    import adda_capture_sequencer_pkg::*;

    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ad_sample;
    logic          arm, abort_s, force_s, rising;
    logic [DW-1:0] level;
    logic [DL-1:0] pretrig;
    logic          busy, done;
    logic [2:0]    state;

    adda_capture_sequencer_if #(.DATA_W(DW)) rd_if ();

    adda_capture_sequencer #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_ad_sample  (ad_sample),
        .i_arm        (arm),
        .i_abort      (abort_s),
        .i_force_trig (force_s),
        .i_trig_rising(rising),
        .i_trig_level (level),
        .i_pretrig    (pretrig),
        .o_busy       (busy),
        .o_state      (state),
        .o_done       (done),
        .rd_if        (rd_if)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    beats    = 0;
    int    done_cnt = 0;
    logic  ramp_en  = 1'b0;
    logic  toggle_ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented beat is compared with the scoreboard head; popped on acceptance.
    always @(negedge clk) begin
        if (rd_if.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", rd_if.rd_data);
            end else begin
                chk("beat_data", rd_if.rd_data, exp_q[0].data);
                chk("beat_last", rd_if.rd_last, exp_q[0].last);
                if (rd_if.rd_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ramp_en) ad_sample = ad_sample + 8'd1;
        if (toggle_ready) rd_if.rd_ready = ~rd_if.rd_ready;
    endtask

    task automatic push_window(input logic [DW-1:0] first);
        beat_t b;
        for (int i = 0; i < DEPTH; i++) begin
            b.data = first + 8'(i);
            b.last = (i == DEPTH - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_arm(input logic [DL-1:0] p);
        pretrig = p;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
    endtask

    // Assert force so that it is sampled on the n-th edge after the arm edge.
    task automatic force_at(input int n, output logic [DW-1:0] trig);
        repeat (n - 1) tick();
        force_s = 1'b1;
        trig    = ad_sample;
        tick();
        force_s = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_done_in_time"}, int'(n < 300), 1);
        repeat (3) tick();
        chk({name, "_done_count"}, done_cnt - start, 1);
        chk({name, "_beats_left"}, exp_q.size(), 0);
        chk({name, "_state_idle"}, state, 0);
        chk({name, "_valid_low"}, rd_if.rd_valid, 0);
    endtask

    task automatic level_capture_ramp(input string name);
        ramp_en   = 1'b1;
        rising    = 1'b1;
        level     = 8'h80;
        ad_sample = 8'h70;
        push_window(8'h7C);
        do_arm(4'd4);
        chk({name, "_prefill"}, state, 1);
        wait_done(name);
    endtask

    initial begin
        logic [DW-1:0] trig;
        int b0;
        int d0;
        int n;

        rst = 1'b1; ad_sample = 8'h00; arm = 1'b0; abort_s = 1'b0; force_s = 1'b0;
        rising = 1'b1; level = 8'h00; pretrig = '0; rd_if.rd_ready = 1'b1;
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rd_if.rd_valid, 0);
        chk("rst_last", rd_if.rd_last, 0);
        chk("rst_data", rd_if.rd_data, 0);
        rst = 1'b0;
        tick();

        // Rising level trigger with 4 pre-trigger samples.
        level_capture_ramp("t1");

        // Forced trigger, P=0: first beat is the trigger sample.
        ramp_en = 1'b1; rising = 1'b1; level = 8'h00; ad_sample = 8'h10;
        do_arm(4'd0);
        chk("t2a_armed", state, 2);
        force_at(10, trig);
        chk("t2a_trig_val", trig, 8'h1A);
        push_window(trig);
        wait_done("t2a");

        // Forced trigger, P=15: last beat is the trigger sample.
        ad_sample = 8'hF0;
        do_arm(4'd15);
        repeat (14) tick();
        chk("t2b_still_prefill", state, 1);
        repeat (10) tick();
        chk("t2b_armed", state, 2);
        force_at(1, trig);
        push_window(trig - 8'd15);
        wait_done("t2b");

        // Falling trigger: first sample after arm must not fire off a stale previous sample.
        ramp_en = 1'b0; rising = 1'b0; level = 8'h40; ad_sample = 8'h50;
        repeat (2) tick();
        push_window(8'h3F);
        do_arm(4'd0);
        ad_sample = 8'h3F;
        repeat (4) tick();
        ad_sample = 8'h50;
        repeat (2) tick();
        chk("t3_no_early_trig", state, 2);
        ad_sample = 8'h3F;
        ramp_en = 1'b1;
        tick();
        chk("t3_trig_post", state, 3);
        wait_done("t3");

        // Back-pressure with ready toggling every cycle.
        rising = 1'b1; level = 8'h00; ad_sample = 8'h20;
        toggle_ready = 1'b1;
        b0 = beats;
        do_arm(4'd8);
        force_at(13, trig);
        push_window(trig - 8'd8);
        wait_done("t4");
        chk("t4_beat_count", beats - b0, DEPTH);
        toggle_ready = 1'b0;
        rd_if.rd_ready = 1'b1;

        // Abort in PREFILL.
        d0 = done_cnt;
        do_arm(4'd8);
        tick();
        chk("t5a_prefill", state, 1);
        abort_s = 1'b1; tick(); abort_s = 1'b0;
        chk("t5a_idle", state, 0);
        chk("t5a_busy", busy, 0);

        // Abort in POST.
        do_arm(4'd0);
        force_at(2, trig);
        repeat (3) tick();
        chk("t5b_post", state, 3);
        abort_s = 1'b1; tick(); abort_s = 1'b0;
        chk("t5b_idle", state, 0);
        chk("t5b_valid", rd_if.rd_valid, 0);

        // Abort mid-readout after beat 7.
        do_arm(4'd0);
        force_at(3, trig);
        push_window(trig);
        b0 = beats;
        n = 0;
        while ((beats - b0) < 7 && n < 200) begin
            tick();
            n++;
        end
        chk("t5c_reached_beat7", int'(n < 200), 1);
        abort_s = 1'b1; tick(); abort_s = 1'b0;
        chk("t5c_idle", state, 0);
        chk("t5c_valid", rd_if.rd_valid, 0);
        chk("t5c_last", rd_if.rd_last, 0);
        exp_q.delete();
        repeat (4) tick();
        chk("t5_no_done", done_cnt - d0, 0);

        // Re-arm after aborts captures cleanly.
        level_capture_ramp("t5d");

        // Arm and abort together in IDLE.
        arm = 1'b1; abort_s = 1'b1; tick(); arm = 1'b0; abort_s = 1'b0;
        chk("t6a_idle", state, 0);
        tick();
        chk("t6a_still_idle", busy, 0);

        // Reset during POST.
        rising = 1'b1; level = 8'h00;
        do_arm(4'd0);
        force_at(2, trig);
        repeat (2) tick();
        chk("t6b_post", state, 3);
        rst = 1'b1; tick();
        chk("t6b_state", state, 0);
        chk("t6b_busy", busy, 0);
        chk("t6b_done", done, 0);
        chk("t6b_valid", rd_if.rd_valid, 0);
        chk("t6b_last", rd_if.rd_last, 0);
        chk("t6b_data", rd_if.rd_data, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("t6b_stays_idle", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
